// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the two-write / two-read register file.
// Optional feature macro used by the top: REG_FILE_MP_BYPASS_EN.
package reg_file_mp_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   // CLEAR: post-reset zeroing sweep; RUN: normal operation until the next rst
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Resolve which write ports commit this cycle.
   // Result is {commit_b, commit_a}; port B wins an address collision.
   function automatic logic [1:0] write_commit(input logic en_a,
                                               input logic en_b,
                                               input logic same_addr);
      return {en_b, en_a & ~(en_b & same_addr)};
   endfunction

endpackage

// File: rtl/reg_file_mp_clear_seq.sv
// Post-reset clear sequencer: sweeps a pointer over every entry, then
// raises ready and stays in RUN until rst. State is exposed for observation.
module reg_file_mp_clear_seq
   import reg_file_mp_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clear_en,
   output logic [ADDR_WIDTH-1:0] clear_addr,
   output logic                  ready,
   output state_t                state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                state_next;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] ptr_next;

   // State and pointer register; rst restarts the sweep from entry 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // Next state: advance pointer in CLEAR, leave on the explicit terminal compare
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      if (state == CLEAR) begin
         ptr_next = ptr + 1'b1;
         if (ptr == LAST_ADDR) begin
            state_next = RUN;
            ptr_next   = '0;
         end
      end
   end

   // Outputs: clear strobe is suppressed while rst is held
   always_comb begin
      clear_en   = (state == CLEAR) && !rst;
      clear_addr = ptr;
      ready      = (state == RUN);
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised 2W/2R register file with post-reset clear, port-B write
// priority and optional hardwired-zero entry 0.
// Optional same-cycle write-to-read bypass: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen_a,
   input  logic [ADDR_WIDTH-1:0] waddr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic                  wen_b,
   input  logic [ADDR_WIDTH-1:0] waddr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clear_en;
   logic [ADDR_WIDTH-1:0] clear_addr;
   state_t                seq_state;
   logic                  run;
   logic                  ok_a;
   logic                  ok_b;
   logic                  commit_a;
   logic                  commit_b;

   reg_file_mp_clear_seq #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .clear_en  (clear_en),
      .clear_addr(clear_addr),
      .ready     (ready),
      .state     (seq_state)
   );

   // Write qualification: only in RUN, never during rst, never to a hardwired zero entry
   always_comb begin
      run  = (seq_state == RUN);
      ok_a = run && !rst && wen_a && !((ZERO_REG != 0) && (waddr_a == '0));
      ok_b = run && !rst && wen_b && !((ZERO_REG != 0) && (waddr_b == '0));
      {commit_b, commit_a} = write_commit(ok_a, ok_b, waddr_a == waddr_b);
   end

   // Array update: clear sweep has the array exclusively; otherwise committed writes
   always_ff @(posedge clk) begin
      if (clear_en) begin
         mem[clear_addr] <= '0;
      end else begin
         if (commit_a) mem[waddr_a] <= wdata_a;
         if (commit_b) mem[waddr_b] <= wdata_b;
      end
   end

   // Read port 1: array value, optional bypass (B over A), zero masking
   always_comb begin
      rdata1 = '0;
      if (run) begin
         rdata1 = mem[raddr1];
`ifdef REG_FILE_MP_BYPASS_EN
         if (commit_a && (waddr_a == raddr1)) rdata1 = wdata_a;
         if (commit_b && (waddr_b == raddr1)) rdata1 = wdata_b;
`endif
         if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
      end
   end

   // Read port 2: same rules as port 1
   always_comb begin
      rdata2 = '0;
      if (run) begin
         rdata2 = mem[raddr2];
`ifdef REG_FILE_MP_BYPASS_EN
         if (commit_a && (waddr_a == raddr2)) rdata2 = wdata_a;
         if (commit_b && (waddr_b == raddr2)) rdata2 = wdata_b;
`endif
         if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2 = '0;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters, ZERO_REG = 1).
// Honours REG_FILE_MP_BYPASS_EN for same-cycle read expectations.
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

`ifdef REG_FILE_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wen_a, wen_b;
   logic [AW-1:0] waddr_a, waddr_b, raddr1, raddr2;
   logic [DW-1:0] wdata_a, wdata_b, rdata1, rdata2;
   logic          ready;

   int checks = 0;
   int errors = 0;

   reg_file_mp dut (
      .clk    (clk),
      .rst    (rst),
      .wen_a  (wen_a),
      .waddr_a(waddr_a),
      .wdata_a(wdata_a),
      .wen_b  (wen_b),
      .waddr_b(waddr_b),
      .wdata_b(wdata_b),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .ready  (ready)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // After reset the file needs DEPTH clean cycles before it is usable; once
   // usable, writes land in order A then B (so B wins), address 0 is never written.
   logic [DW-1:0] model_mem [DEPTH];
   int            clear_left = 0;
   bit            model_ready = 1'b0;
   bit            model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         clear_left  = DEPTH;
         model_ready = 1'b0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (!model_ready) begin
            model_mem[DEPTH - clear_left] = '0;
            clear_left--;
            if (clear_left == 0) model_ready = 1'b1;
         end else begin
            if (wen_a && waddr_a != 0) model_mem[waddr_a] = wdata_a;
            if (wen_b && waddr_b != 0) model_mem[waddr_b] = wdata_b;
         end
      end
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
      if (!model_ready || addr == 0) return '0;
      if (BYP && !rst && wen_b && waddr_b == addr) return wdata_b;
      if (BYP && !rst && wen_a && waddr_a == addr) return wdata_a;
      return model_mem[addr];
   endfunction

   // compare process: every negedge once the model has seen a reset
   always @(negedge clk) begin
      if (model_valid) begin
         check("ready", {31'b0, ready}, {31'b0, model_ready});
         check("rdata1", rdata1, model_read(raddr1));
         check("rdata2", rdata2, model_read(raddr2));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_writes();
      wen_a = 1'b0;
      wen_b = 1'b0;
   endtask

   // counts cycles until ready; writes are dropped the moment ready is seen
   task automatic wait_ready(output int n);
      bit seen = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         n++;
         if (ready) begin
            seen = 1'b1;
            idle_writes();
         end
      end
      if (!seen) idle_writes();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      logic [DW-1:0] v;

      rst = 1'b1;
      idle_writes();
      waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
      raddr1 = 5'd5; raddr2 = 5'd0;

      // reset held 3 cycles
      repeat (3) @(posedge clk);
      tick();
      check("reset_ready", {31'b0, ready}, 32'd0);
      check("reset_rdata1", rdata1, 32'h0);

      // clear sequence: 32 cycles of ready low
      rst = 1'b0;
      wait_ready(n);
      check("clear_cycles", n, 32'd32);

      for (int i = 0; i < DEPTH; i++) begin
         raddr1 = AW'(i);
         raddr2 = AW'(DEPTH - 1 - i);
         #1;
         check("cleared_r1", rdata1, 32'h0);
         check("cleared_r2", rdata2, 32'h0);
         tick();
      end

      // single write, port A
      wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
      raddr1 = 5'd5; raddr2 = 5'd6;
      #1;
      check("single_same_cycle", rdata1, BYP ? 32'hDEADBEEF : 32'h0);
      tick();
      idle_writes();
      #1;
      check("single_r1", rdata1, 32'hDEADBEEF);
      check("single_r2", rdata2, 32'h0);

      // overwrite: same-cycle read shows old or new value
      wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h12345678;
      #1;
      check("overwrite_same_cycle", rdata1, BYP ? 32'h12345678 : 32'hDEADBEEF);
      tick();
      idle_writes();
      #1;
      check("overwrite_after", rdata1, 32'h12345678);

      // conflict: both ports to addr 9, B wins
      wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h11111111;
      wen_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h22222222;
      raddr1 = 5'd9;
      #1;
      check("conflict_same_cycle", rdata1, BYP ? 32'h22222222 : 32'h0);
      tick();
      idle_writes();
      #1;
      check("conflict_after", rdata1, 32'h22222222);

      // dual write to distinct addresses
      wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hA;
      wen_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'hB;
      tick();
      idle_writes();
      raddr1 = 5'd3; raddr2 = 5'd4;
      #1;
      check("dual_a", rdata1, 32'hA);
      check("dual_b", rdata2, 32'hB);

      // zero entry ignores writes on both ports
      wen_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF;
      wen_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFFFFFF;
      raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      check("zero_same_cycle", rdata1, 32'h0);
      tick();
      idle_writes();
      #1;
      check("zero_after", rdata1, 32'h0);

      // burst of dual writes; the compare process checks readback
      for (int i = 10; i < 18; i++) begin
         wen_a = 1'b1; waddr_a = AW'(i);     wdata_a = 32'h01010101 * i;
         wen_b = 1'b1; waddr_b = AW'(i + 8); wdata_b = ~(32'h01010101 * i);
         raddr1 = AW'(i); raddr2 = AW'(i + 7);
         tick();
      end
      idle_writes();
      for (int i = 10; i < 26; i++) begin
         raddr1 = AW'(i);
         tick();
      end
      raddr1 = 5'd12; raddr2 = 5'd20;
      #1;
      v = 32'h0C0C0C0C;
      check("burst_a12", rdata1, v);
      check("burst_b20", rdata2, ~v);

      // reset mid-RUN with a write pending, then pulse rst at clear-cycle 10
      rst = 1'b1;
      wen_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'h0000CAFE;
      tick();
      check("rst_run_ready", {31'b0, ready}, 32'd0);
      rst = 1'b0;
      wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h00000077;
      wen_b = 1'b1; waddr_b = 5'd31; wdata_b = 32'h00000031;
      repeat (10) tick();
      check("clear10_ready", {31'b0, ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(n);
      check("reclear_cycles", n, 32'd32);
      raddr1 = 5'd7; raddr2 = 5'd20;
      #1;
      check("clear_write_dropped", rdata1, 32'h0);
      check("rst_write_dropped", rdata2, 32'h0);
      raddr1 = 5'd31; raddr2 = 5'd9;
      #1;
      check("clear_write_b_dropped", rdata1, 32'h0);
      check("old_data_cleared", rdata2, 32'h0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
